// File: rtl/mult_control.sv
// mult_control
//   Control FSM for the 4-bit shift-add sequential multiplier. It drives the
//   register enables and mux selects of Mult_Data_Path, consumes that
//   datapath's registered zero / lsb_b flags, and offers a start/busy/done
//   handshake. Each start produces one product. Outputs are Moore outputs,
//   decoded from the state register only.
//
//   Optional feature: define MULT_EARLY_EXIT_EN to stop the operation as soon
//   as b becomes zero. Without it, exactly WIDTH shifts are always performed.
//
//   Ports
//     clk         in   system clock, rising edge
//     clr         in   asynchronous reset, active low
//     start       in   request a multiply; sampled only in IDLE
//     zero        in   datapath flag, registered (b == 0)
//     lsb_b       in   datapath flag, registered b[0]
//     en_a        out  register a enable
//     ld_shift_a  out  a mux select: 0 = load a_in, 1 = shift
//     en_b        out  register b enable
//     ld_shift_b  out  b mux select: 0 = load b_in, 1 = shift
//     en_p        out  register p enable
//     ld_add_p    out  p mux select: 0 = clear, 1 = a + p
//     busy        out  high in every state except IDLE
//     done        out  one-cycle pulse; the product on p is valid in this cycle
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | load a and b, clear p, clear the iteration counter
//   WAIT  | let the registered flags catch up with the new b
//   TEST  | pick the next step: finish, add, or shift only
//   ADD   | p <= p + a
//   SHIFT | a <<= 1, b >>= 1, cnt++
//   DONE  | product valid; pulse done

module mult_control #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic zero,
  input  logic lsb_b,
  output logic en_a,
  output logic ld_shift_a,
  output logic en_b,
  output logic ld_shift_b,
  output logic en_p,
  output logic ld_add_p,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    TEST  = 3'd3,
    ADD   = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          early_exit;

`ifdef MULT_EARLY_EXIT_EN
  assign early_exit = zero;
`else
  // This build ignores zero. It stays in the expression only so that the
  // port remains connected to logic.
  assign early_exit = zero & 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cnt is only incremented in SHIFT, and TEST leaves the loop once
  // cnt reaches WIDTH, so cnt can never go past WIDTH.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (state == LOAD) begin
      cnt <= '0;
    end else if (state == SHIFT) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    en_a       = 1'b0;
    ld_shift_a = 1'b0;
    en_b       = 1'b0;
    ld_shift_b = 1'b0;
    en_p       = 1'b0;
    ld_add_p   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        en_a       = 1'b1;
        en_b       = 1'b1;
        en_p       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        state_next = TEST;
      end
      TEST: begin
        // The zero test comes first, so it beats lsb_b when both flags are set.
        if (early_exit)                 state_next = DONE;
        else if (cnt == CW'(WIDTH))     state_next = DONE;
        else if (lsb_b)                 state_next = ADD;
        else                            state_next = SHIFT;
      end
      ADD: begin
        en_p       = 1'b1;
        ld_add_p   = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        en_a       = 1'b1;
        ld_shift_a = 1'b1;
        en_b       = 1'b1;
        ld_shift_b = 1'b1;
        state_next = WAIT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control
//   Self-checking bench for mult_control. A simple shift-add datapath model
//   closes the loop by producing the registered zero / lsb_b flags. For each
//   operation, a reference model computes the product, the cycle in which done
//   appears, and the number of ADD and SHIFT cycles directly from the operand
//   values. The expected results follow MULT_EARLY_EXIT_EN the same way the
//   design does.

module tb_mult_control;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic start = 1'b0;
  logic zero, lsb_b;
  logic en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done;

  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;
  logic [7:0] ra, rp;
  logic [3:0] rb;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] outs;
  assign outs = {en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done};

  always #5 clk = ~clk;

  mult_control #(.WIDTH(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .zero       (zero),
    .lsb_b      (lsb_b),
    .en_a       (en_a),
    .ld_shift_a (ld_shift_a),
    .en_b       (en_b),
    .ld_shift_b (ld_shift_b),
    .en_p       (en_p),
    .ld_add_p   (ld_add_p),
    .busy       (busy),
    .done       (done)
  );

  // Datapath model: a shifts left into 8 bits, b shifts right, and p
  // accumulates. The flags are registered copies of the b register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ra    <= '0;
      rb    <= '0;
      rp    <= '0;
      zero  <= 1'b1;
      lsb_b <= 1'b0;
    end else begin
      if (en_a) ra <= ld_shift_a ? (ra << 1) : {4'b0, a_in};
      if (en_b) rb <= ld_shift_b ? (rb >> 1) : b_in;
      if (en_p) rp <= ld_add_p ? (rp + ra) : 8'd0;
      zero  <= (rb == 4'd0);
      lsb_b <= rb[0];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model. Each iteration costs WAIT+TEST+SHIFT, plus an ADD cycle
  // when the current lsb of b is 1. The count starts at 1 for LOAD, and the
  // finishing WAIT+TEST+DONE adds 3 more.
  function automatic int ref_iters(input logic [3:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int n = 0;
    for (int i = 0; i < 4; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 4;
`endif
  endfunction

  function automatic int ref_latency(input logic [3:0] b);
    return 1 + 3 * ref_iters(b) + $countones(b) + 3;
  endfunction

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input bit hold, input bit repulse);
    int cyc, adds, shifts;
    bit got;
    @(negedge clk);
    check("idle_before_op", int'(busy), 0);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    cyc = 0; adds = 0; shifts = 0; got = 0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (!hold) begin
        if (repulse && cyc >= 2 && cyc <= 10) start = 1'($urandom_range(0, 1));
        else start = 1'b0;
      end
      if (cyc == 1) check("load_outputs", int'(outs), 8'b1010_1010);
      if (en_p && ld_add_p)   adds++;
      if (en_a && ld_shift_a) shifts++;
      if (done) got = 1;
      else if (!busy) begin
        check("busy_during_op", 0, 1);
        got = 1;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    check("done_cycle", cyc, ref_latency(b));
    check("product", int'(rp), int'(a) * int'(b));
    check("add_cycles", adds, $countones(b));
    check("shift_cycles", shifts, ref_iters(b));
    if (repulse) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("no_extra_done", int'({busy, done}), 0);
      end
    end
  endtask

  initial begin
    int cyc;
    logic [3:0] ra_r, rb_r;

    repeat (2) @(negedge clk);
    check("reset_outputs", int'(outs), 0);
    clr = 1'b1;
    @(negedge clk);
    check("after_reset_idle", int'(outs), 0);

    // Directed cases: b = 0, a sparse b, and full 15x15.
    run_op(4'd7, 4'd0, 0, 0);
    run_op(4'd3, 4'b0101, 0, 0);
    run_op(4'd15, 4'b1111, 0, 0);
    run_op(4'd9, 4'b1000, 0, 0);

    // Re-pulsing start while busy. b[3] is set so the op runs past cycle 10.
    run_op(4'($urandom_range(0, 15)), 4'b1000 | 4'($urandom_range(0, 7)), 0, 1);

    // start held high across two operations.
    run_op(4'd11, 4'b0110, 1, 0);
    run_op(4'd5, 4'b1101, 0, 0);

    // Random operations, some of them back to back.
    for (int i = 0; i < 12; i++) begin
      ra_r = 4'($urandom_range(0, 15));
      rb_r = 4'($urandom_range(0, 15));
      run_op(ra_r, rb_r, bit'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of an ADD cycle.
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in  = 4'd6;
    b_in  = 4'b1011;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(en_p && ld_add_p) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_add", int'(en_p && ld_add_p), 1);
    #2 clr = 1'b0;
    #1 check("mid_add_reset_outputs", int'(outs), 0);
    @(negedge clk);
    check("held_reset_outputs", int'(outs), 0);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_idle", int'(outs), 0);
    end
    run_op(4'd6, 4'b1011, 0, 0);

    @(negedge clk);
    check("final_idle", int'({busy, done}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
